// File: rtl/mux_nway_arb.sv
// mux_nway_arb: N-channel, W-bit multiplexer with valid/ready handshakes.
// The source channel is picked by round-robin, by fixed priority (lowest
// index wins) or by a manual force select. The chosen word is captured in a
// one-entry output register that can drain and reload on the same edge.
//
// Handshake semantics (every port pair): a word moves across an interface on
// a rising clk edge where valid & ready are both high. Producers hold data
// stable while valid is high and ready is low. in_ready is combinational and
// depends on in_valid, mode, force_en, force_sel, out_ready and the register
// state; out_valid/out_data/out_chan come straight from flops.
//
// CHANNELS must be >= 2 and SEL_W must equal ceil(log2(CHANNELS)).
module mux_nway_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      dbg_state
);

  // Output register occupancy.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic [CHANNELS-1:0] w_elig;
  logic [CHANNELS-1:0] w_req;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_gidx;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_can_load;
  logic                w_load;

  // Eligibility: force restricts to one channel; an out-of-range force_sel
  // matches no index, so nothing is eligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_elig[i] = force_en ? (force_sel == SEL_W'(i)) : 1'b1;
    end
  end

  assign w_req = in_valid & w_elig;

  // Grant: scan eligible requests starting at ptr (round-robin) or at 0
  // (fixed priority); first hit wins, so the grant is at most one-hot.
  // With force active only one request can be set, so the start point does
  // not matter there.
  always_comb begin : p_grant
    int   base;
    int   idx;
    logic found;
    w_grant    = '0;
    w_gidx     = '0;
    w_sel_data = '0;
    found      = 1'b0;
    idx        = 0;
    base       = mode ? 0 : int'(r_ptr);
    for (int k = 0; k < CHANNELS; k++) begin
      idx = base + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && w_req[idx]) begin
        found        = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = SEL_W'(idx);
        w_sel_data   = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Load when the register is empty or draining this cycle; no transfer is
  // offered while reset is held.
  assign w_can_load = (r_state == S_EMPTY) | out_ready;
  assign w_load     = w_can_load & (|w_req) & ~rst;
  assign in_ready   = rst ? '0 : (w_grant & {CHANNELS{w_can_load}});

  // Pointer moves past the granted channel, wrapping at CHANNELS-1.
  always_comb begin
    w_ptr_nxt = w_gidx + 1'b1;
    if (w_gidx == SEL_W'(CHANNELS - 1)) w_ptr_nxt = '0;
  end

  // Next occupancy: a load always fills; a drain without load empties.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = S_FULL;
    end else if ((r_state == S_FULL) && out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Captured word, source index and round-robin pointer; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_chan <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_data <= w_sel_data;
      r_chan <= w_gidx;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = (r_state == S_FULL);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Directed bench for mux_nway_arb (4 x 16 bits). Expected output words are
// queued as each transfer is set up and compared when the word is consumed.
module tb_mux_nway_arb;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic                      force_en;
  logic [SEL_W-1:0]          force_sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      dbg_state;

  mux_nway_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [SEL_W+WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]       data_tbl [CHANNELS];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch);
    logic [SEL_W-1:0] c;
    c = SEL_W'(ch);
    exp_q.push_back({c, data_tbl[ch]});
  endtask

  // Driver: set all control inputs at once.
  task automatic drive(input logic [CHANNELS-1:0] v, input logic m,
                       input logic fe, input logic [SEL_W-1:0] fs, input logic ordy);
    in_valid  = v;
    mode      = m;
    force_en  = fe;
    force_sel = fs;
    out_ready = ordy;
    #1;
  endtask

  // One cycle: at the falling edge compare any word being consumed, then
  // advance past the next rising edge.
  task automatic tick();
    logic [SEL_W+WIDTH-1:0] exp_w;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%h expected=none", {out_chan, out_data});
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk("sb_word", {14'd0, out_chan, out_data}, {14'd0, exp_w});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    data_tbl[0] = 16'h0000;
    data_tbl[1] = 16'hFFFF;
    data_tbl[2] = 16'h5555;
    data_tbl[3] = 16'h00FF;
    for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = data_tbl[i];
    in_valid = '0; mode = 1'b0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;

    // Reset state, with requests present to prove in_ready is gated.
    drive(4'b1111, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dbg_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // 1. Fixed priority: ch0 always wins.
    for (int i = 0; i < 4; i++) begin
      chk("fp_in_ready", in_ready, 4'b0001);
      push_exp(0);
      tick();
      chk("fp_out_valid", out_valid, 1);
      chk("fp_out_chan", out_chan, 0);
    end

    // 2. Round-robin with all valid; ptr is 1 after the fixed-priority grants.
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("rr_in_ready", in_ready, 32'(1 << ((i + 1) % 4)));
      push_exp((i + 1) % 4);
      tick();
    end

    // 3. Skip and wrap: ptr=0, only ch1/ch3 requesting.
    drive(4'b1010, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push_exp((i % 2 == 0) ? 1 : 3);
      tick();
    end
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("rr_wrap_in_ready", in_ready, 4'b0001);
    push_exp(0);
    tick();

    // 4. Forced select overrides round-robin.
    for (int s = 0; s < 4; s++) begin
      drive(4'b1111, 1'b0, 1'b1, 2'(s), 1'b1);
      chk("force_in_ready", in_ready, 32'(1 << s));
      push_exp(s);
      tick();
      chk("force_out_data", out_data, data_tbl[s]);
    end
    drive(4'b1011, 1'b0, 1'b1, 2'd2, 1'b1);
    chk("force_idle_in_ready", in_ready, 0);
    tick();
    chk("force_idle_out_valid", out_valid, 0);

    // 5. Backpressure: load ch1, then stall for 5 cycles.
    drive(4'b0010, 1'b0, 1'b0, 2'd0, 1'b1);
    push_exp(1);
    tick();
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 16'hFFFF);
      chk("bp_out_chan", out_chan, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("bp_release_in_ready", in_ready, 4'b0100);
    push_exp(2);
    tick();
    chk("bp_reload_data", out_data, 16'h5555);
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    chk("drain_out_valid", out_valid, 0);

    // 6. Async reset while the register holds ch3's word.
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("pre_rst_in_ready", in_ready, 4'b1000);
    @(posedge clk); #1;
    in_valid = 4'b0000;
    chk("pre_rst_out_chan", out_chan, 3);
    chk("pre_rst_out_data", out_data, 16'h00FF);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 0);
    in_valid = 4'b1111;
    @(posedge clk); #1;
    chk("rst_cycle_no_load", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 4'b0001);
    push_exp(0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
